// File: rtl/shwr_summary_fifo_if.sv
// Bundle of upstream shower-summary inputs, FIFO read/clear controls and
// head-entry outputs for shwr_summary_fifo. Clock and reset stay plain ports.
interface shwr_summary_fifo_if #(
    parameter int ADC_WIDTH  = 12,
    parameter int AREA_WIDTH = 19,
    parameter int BL_WIDTH   = 14,
    parameter int DEPTH      = 4
);
    // Capture side
    logic                       ENABLE;
    logic                       TRIGGERED;
    logic [AREA_WIDTH-1:0]      INTEGRAL;
    logic [ADC_WIDTH-1:0]       PEAK;
    logic [BL_WIDTH-1:0]        BASELINE;
    logic                       SATURATED;

    // Read side
    logic                       RD_EN;
    logic                       CLR_LOST;
    logic                       EVT_VALID;
    logic [AREA_WIDTH-1:0]      EVT_AREA;
    logic [ADC_WIDTH-1:0]       EVT_PEAK;
    logic [BL_WIDTH-1:0]        EVT_BASELINE;
    logic                       EVT_SAT;
    logic [11:0]                EVT_DURATION;
    logic [3:0]                 EVT_SEQ;
    logic [$clog2(DEPTH):0]     FIFO_COUNT;
    logic [7:0]                 LOST_COUNT;

    // Environment side: drives the upstream values and read controls
    modport master (
        output ENABLE, TRIGGERED, INTEGRAL, PEAK, BASELINE, SATURATED,
        output RD_EN, CLR_LOST,
        input  EVT_VALID, EVT_AREA, EVT_PEAK, EVT_BASELINE, EVT_SAT,
        input  EVT_DURATION, EVT_SEQ, FIFO_COUNT, LOST_COUNT
    );

    // FIFO side
    modport slave (
        input  ENABLE, TRIGGERED, INTEGRAL, PEAK, BASELINE, SATURATED,
        input  RD_EN, CLR_LOST,
        output EVT_VALID, EVT_AREA, EVT_PEAK, EVT_BASELINE, EVT_SAT,
        output EVT_DURATION, EVT_SEQ, FIFO_COUNT, LOST_COUNT
    );
endinterface

// File: rtl/shwr_summary_fifo.sv
// Shower summary FIFO: at the falling edge of each integration window, snapshot
// the upstream integral/peak/baseline/saturation together with the window
// length and a sequence number, and queue it in a small show-ahead FIFO.
// Captures arriving while the FIFO is full (and not being read) are counted.
module shwr_summary_fifo #(
    parameter int ADC_WIDTH  = 12,
    parameter int AREA_WIDTH = 19,
    parameter int BL_WIDTH   = 14,
    parameter int DEPTH      = 4
) (
    input logic                CLK120,
    input logic                RESETN,
    shwr_summary_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [11:0] DUR_MAX  = 12'hFFF;
    localparam logic [7:0]  LOST_MAX = 8'hFF;

    typedef struct packed {
        logic [AREA_WIDTH-1:0] area;
        logic [ADC_WIDTH-1:0]  peak;
        logic [BL_WIDTH-1:0]   bl;
        logic                  sat;
        logic [11:0]           dur;
        logic [3:0]            seq;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head_q, head_d;
    entry_t        cap_entry;
    logic          trig_d_q;
    logic          armed_q;
    logic [11:0]   dur_q, dur_d;
    logic [3:0]    seq_q, seq_d;
    logic [7:0]    lost_q, lost_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_q, count_d;

    logic win_end, capture, evt_valid, full, pop, push, drop;

    // A window end is the live falling edge of TRIGGERED. The armed flag
    // requires TRIGGERED to have been seen low since reset, so a window that
    // was already open when reset was released is discarded.
    assign win_end   = trig_d_q & ~bus.TRIGGERED & armed_q;
    assign capture   = win_end & bus.ENABLE;
    assign evt_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = bus.RD_EN & evt_valid;
    assign push      = capture & (~full | bus.RD_EN);
    assign drop      = capture & full & ~bus.RD_EN;
    assign rd_next   = rd_ptr_q + AW'(1);

    // Snapshot of the final upstream values at the window end
    always_comb begin
        cap_entry      = '0;
        cap_entry.area = bus.INTEGRAL;
        cap_entry.peak = bus.PEAK;
        cap_entry.bl   = bus.BASELINE;
        cap_entry.sat  = bus.SATURATED;
        cap_entry.dur  = dur_q;
        cap_entry.seq  = seq_q;
    end

    // Next-state logic for counters, pointers, occupancy and the head register
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        dur_d    = dur_q;
        seq_d    = seq_q;
        lost_d   = lost_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (!bus.TRIGGERED) begin
            dur_d = '0;
        end else if (dur_q != DUR_MAX) begin
            dur_d = dur_q + 12'd1;
        end

        if (capture) begin
            seq_d = seq_q + 4'd1;
        end

        if (bus.CLR_LOST) begin
            lost_d = drop ? 8'd1 : 8'd0;
        end else if (drop && lost_q != LOST_MAX) begin
            lost_d = lost_q + 8'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head register: load the new capture when it becomes the head,
        // otherwise advance to the next stored entry on a pop. It holds its
        // last value once the FIFO drains.
        if (push && (count_q == '0 || (pop && count_q == CW'(1)))) begin
            head_d = cap_entry;
        end else if (pop && count_q > CW'(1)) begin
            head_d = mem[rd_next];
        end
    end

    // Control and head-entry state registers
    always_ff @(posedge CLK120 or negedge RESETN) begin
        if (!RESETN) begin
            trig_d_q <= 1'b0;
            armed_q  <= 1'b0;
            dur_q    <= '0;
            seq_q    <= '0;
            lost_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            trig_d_q <= bus.TRIGGERED;
            armed_q  <= armed_q | ~bus.TRIGGERED;
            dur_q    <= dur_d;
            seq_q    <= seq_d;
            lost_q   <= lost_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Entry storage
    // NOTE: the storage array has no reset; pointers and count define which entries are live.
    always_ff @(posedge CLK120) begin
        if (push) begin
            mem[wr_ptr_q] <= cap_entry;
        end
    end

    assign bus.EVT_VALID    = evt_valid;
    assign bus.EVT_AREA     = head_q.area;
    assign bus.EVT_PEAK     = head_q.peak;
    assign bus.EVT_BASELINE = head_q.bl;
    assign bus.EVT_SAT      = head_q.sat;
    assign bus.EVT_DURATION = head_q.dur;
    assign bus.EVT_SEQ      = head_q.seq;
    assign bus.FIFO_COUNT   = count_q;
    assign bus.LOST_COUNT   = lost_q;

endmodule

// File: tb/tb_shwr_summary_fifo.sv
// Self-checking bench for shwr_summary_fifo: a queue-based reference model
// predicts the outputs every cycle; directed scenarios add literal checks.
module tb_shwr_summary_fifo;
    localparam int ADC_WIDTH  = 12;
    localparam int AREA_WIDTH = 19;
    localparam int BL_WIDTH   = 14;
    localparam int DEPTH      = 4;

    typedef struct packed {
        logic [AREA_WIDTH-1:0] area;
        logic [ADC_WIDTH-1:0]  peak;
        logic [BL_WIDTH-1:0]   bl;
        logic                  sat;
        logic [11:0]           dur;
        logic [3:0]            seq;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shwr_summary_fifo_if #(
        .ADC_WIDTH(ADC_WIDTH), .AREA_WIDTH(AREA_WIDTH),
        .BL_WIDTH(BL_WIDTH), .DEPTH(DEPTH)
    ) bus ();

    shwr_summary_fifo #(
        .ADC_WIDTH(ADC_WIDTH), .AREA_WIDTH(AREA_WIDTH),
        .BL_WIDTH(BL_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .CLK120 (clk),
        .RESETN (rst_n),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    ent_t mq[$];
    ent_t m_head;
    int   m_lost, m_seq, m_dur;
    bit   m_trig_prev, m_armed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head      = '0;
        m_lost      = 0;
        m_seq       = 0;
        m_dur       = 0;
        m_trig_prev = 0;
        m_armed     = 0;
    endtask

    // Effect of the coming rising edge, given the inputs now applied
    task automatic model_step();
        ent_t e;
        bit   cap, drop, pop;
        pop  = bus.RD_EN && (mq.size() > 0);
        cap  = m_trig_prev && !bus.TRIGGERED && m_armed && bus.ENABLE;
        e.area = bus.INTEGRAL;
        e.peak = bus.PEAK;
        e.bl   = bus.BASELINE;
        e.sat  = bus.SATURATED;
        e.dur  = 12'(m_dur);
        e.seq  = 4'(m_seq);
        if (cap) m_seq = (m_seq + 1) % 16;
        drop = cap && (mq.size() == DEPTH) && !bus.RD_EN;
        if (pop) void'(mq.pop_front());
        if (cap && !drop) mq.push_back(e);
        if (bus.CLR_LOST) m_lost = drop ? 1 : 0;
        else if (drop && m_lost < 255) m_lost++;
        m_dur = bus.TRIGGERED ? ((m_dur < 4095) ? m_dur + 1 : 4095) : 0;
        if (!bus.TRIGGERED) m_armed = 1;
        m_trig_prev = bus.TRIGGERED;
        if (mq.size() > 0) m_head = mq[0];
    endtask

    task automatic compare();
        check("valid",    32'(bus.EVT_VALID),    32'(mq.size() != 0));
        check("count",    32'(bus.FIFO_COUNT),   32'(mq.size()));
        check("lost",     32'(bus.LOST_COUNT),   32'(m_lost));
        check("area",     32'(bus.EVT_AREA),     32'(m_head.area));
        check("peak",     32'(bus.EVT_PEAK),     32'(m_head.peak));
        check("baseline", 32'(bus.EVT_BASELINE), 32'(m_head.bl));
        check("sat",      32'(bus.EVT_SAT),      32'(m_head.sat));
        check("duration", 32'(bus.EVT_DURATION), 32'(m_head.dur));
        check("seq",      32'(bus.EVT_SEQ),      32'(m_head.seq));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    // Called 1 time unit after a rising edge: pulse reset between edges
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 32'(bus.EVT_VALID),    0);
        check("rst_count", 32'(bus.FIFO_COUNT),   0);
        check("rst_lost",  32'(bus.LOST_COUNT),   0);
        check("rst_area",  32'(bus.EVT_AREA),     0);
        check("rst_peak",  32'(bus.EVT_PEAK),     0);
        check("rst_dur",   32'(bus.EVT_DURATION), 0);
        check("rst_seq",   32'(bus.EVT_SEQ),      0);
        #2 rst_n = 1'b1;
    endtask

    task automatic rand_data();
        bus.INTEGRAL  = AREA_WIDTH'($urandom);
        bus.PEAK      = ADC_WIDTH'($urandom);
        bus.BASELINE  = BL_WIDTH'($urandom);
        bus.SATURATED = 1'($urandom);
    endtask

    task automatic window(input int len, input bit rd_end, input bit clr_end);
        bus.TRIGGERED = 1'b1;
        repeat (len) tick();
        bus.TRIGGERED = 1'b0;
        bus.RD_EN     = rd_end;
        bus.CLR_LOST  = clr_end;
        tick();
        bus.RD_EN     = 1'b0;
        bus.CLR_LOST  = 1'b0;
        tick();
    endtask

    task automatic pop1();
        bus.RD_EN = 1'b1;
        tick();
        bus.RD_EN = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ENABLE    = 1'b0;
        bus.TRIGGERED = 1'b0;
        bus.INTEGRAL  = '0;
        bus.PEAK      = '0;
        bus.BASELINE  = '0;
        bus.SATURATED = 1'b0;
        bus.RD_EN     = 1'b0;
        bus.CLR_LOST  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        repeat (2) tick();

        // Single capture with held upstream values, then a short window
        bus.ENABLE = 1'b1;
        bus.INTEGRAL = 19'd5000; bus.PEAK = 12'd812; bus.BASELINE = 14'd1000; bus.SATURATED = 1'b1;
        bus.TRIGGERED = 1'b1;
        repeat (100) tick();
        bus.TRIGGERED = 1'b0;
        tick();
        check("single_valid", 32'(bus.EVT_VALID),    1);
        check("single_area",  32'(bus.EVT_AREA),     5000);
        check("single_peak",  32'(bus.EVT_PEAK),     812);
        check("single_bl",    32'(bus.EVT_BASELINE), 1000);
        check("single_sat",   32'(bus.EVT_SAT),      1);
        check("single_dur",   32'(bus.EVT_DURATION), 100);
        check("single_seq",   32'(bus.EVT_SEQ),      0);
        tick();
        pop1();
        check("drained_valid", 32'(bus.EVT_VALID), 0);
        check("hold_area",     32'(bus.EVT_AREA),  5000);
        pop1();
        check("empty_rd_count", 32'(bus.FIFO_COUNT), 0);
        window(1, 1'b0, 1'b0);
        check("short_dur", 32'(bus.EVT_DURATION), 1);
        check("short_seq", 32'(bus.EVT_SEQ),      1);

        // Overflow: six windows, no reads
        do_reset();
        repeat (2) tick();
        for (int i = 0; i < 6; i++) begin
            rand_data();
            window(3, 1'b0, 1'b0);
        end
        check("ovf_count", 32'(bus.FIFO_COUNT), 4);
        check("ovf_lost",  32'(bus.LOST_COUNT), 2);
        for (int i = 0; i < 4; i++) begin
            check("ovf_seq", 32'(bus.EVT_SEQ), 32'(i));
            pop1();
        end
        check("ovf_empty", 32'(bus.EVT_VALID), 0);

        // Push and pop on a full FIFO
        do_reset();
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            rand_data();
            window(2, 1'b0, 1'b0);
        end
        rand_data();
        window(2, 1'b1, 1'b0);
        check("pp_count", 32'(bus.FIFO_COUNT), 4);
        check("pp_lost",  32'(bus.LOST_COUNT), 0);
        check("pp_head",  32'(bus.EVT_SEQ),    1);
        repeat (3) pop1();
        check("pp_last_seq", 32'(bus.EVT_SEQ),    4);
        check("pp_last_cnt", 32'(bus.FIFO_COUNT), 1);
        pop1();

        // ENABLE gating
        do_reset();
        repeat (2) tick();
        bus.ENABLE = 1'b0;
        repeat (3) window(4, 1'b0, 1'b0);
        bus.ENABLE = 1'b1;
        window(4, 1'b0, 1'b0);
        check("gate_count", 32'(bus.FIFO_COUNT), 1);
        check("gate_seq",   32'(bus.EVT_SEQ),    0);

        // Duration saturation, then lost-count clear coincident with a drop
        do_reset();
        repeat (2) tick();
        window(5000, 1'b0, 1'b0);
        check("sat_dur", 32'(bus.EVT_DURATION), 4095);
        repeat (3) window(2, 1'b0, 1'b0);
        window(2, 1'b0, 1'b0);
        check("drop_lost", 32'(bus.LOST_COUNT), 1);
        window(2, 1'b0, 1'b1);
        check("clr_drop_lost", 32'(bus.LOST_COUNT), 1);
        check("clr_count",     32'(bus.FIFO_COUNT), 4);

        // Asynchronous reset mid-window with two entries stored
        do_reset();
        repeat (2) tick();
        repeat (2) window(3, 1'b0, 1'b0);
        bus.TRIGGERED = 1'b1;
        repeat (10) tick();
        check("pre_rst_count", 32'(bus.FIFO_COUNT), 2);
        do_reset();
        repeat (5) tick();
        bus.TRIGGERED = 1'b0;
        repeat (2) tick();
        check("post_rst_count", 32'(bus.FIFO_COUNT), 0);
        check("post_rst_valid", 32'(bus.EVT_VALID),  0);
        window(3, 1'b0, 1'b0);
        check("post_rst_seq", 32'(bus.EVT_SEQ), 0);

        // Randomized traffic with varying read pressure
        do_reset();
        repeat (2) tick();
        for (int seg = 0; seg < 4; seg++) begin
            int rd_pct;
            rd_pct = (seg == 0) ? 0 : (seg == 1) ? 10 : (seg == 2) ? 50 : 90;
            for (int c = 0; c < 750; c++) begin
                if ($urandom_range(0, 5) == 0) bus.TRIGGERED = ~bus.TRIGGERED;
                bus.ENABLE   = ($urandom_range(0, 7) != 0);
                bus.RD_EN    = ($urandom_range(0, 99) < rd_pct);
                bus.CLR_LOST = ($urandom_range(0, 63) == 0);
                rand_data();
                tick();
            end
        end
        bus.RD_EN = 1'b0;
        bus.CLR_LOST = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
